// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: master request/ack ports and shared data-bus signals of the arbiter.
// master modport is the arbiter's view; slave modport is the masters' and bus environment's view.
interface bus_arbiter_if #(
    parameter int ADDR_BIT_WIDTH = 32,
    parameter int DATA_BIT_WIDTH = 32
);
    logic                      m0_req, m0_we, m0_gnt, m0_ack;
    logic [ADDR_BIT_WIDTH-1:0] m0_addr;
    logic [DATA_BIT_WIDTH-1:0] m0_wdata, m0_rdata;
    logic                      m1_req, m1_we, m1_gnt, m1_ack;
    logic [ADDR_BIT_WIDTH-1:0] m1_addr;
    logic [DATA_BIT_WIDTH-1:0] m1_wdata, m1_rdata;
    logic [ADDR_BIT_WIDTH-1:0] bus_addr;
    logic                      bus_wrtEn, dbus_oe;
    logic [DATA_BIT_WIDTH-1:0] dbus_out, dbus_in;

    modport master (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata, dbus_in,
        output m0_gnt, m0_ack, m0_rdata, m1_gnt, m1_ack, m1_rdata,
        output bus_addr, bus_wrtEn, dbus_oe, dbus_out
    );

    modport slave (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata, dbus_in,
        input  m0_gnt, m0_ack, m0_rdata, m1_gnt, m1_ack, m1_rdata,
        input  bus_addr, bus_wrtEn, dbus_oe, dbus_out
    );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin arbiter and sequencer with device-region wait states.
// Define BUS_ARB_FIXED_PRIO_EN to make M0 always win ties.
module bus_arbiter #(
    parameter int ADDR_BIT_WIDTH = 32,
    parameter int DATA_BIT_WIDTH = 32,
    parameter int DEV_WAIT       = 2,
    parameter int WAIT_CNT_WIDTH = 4
) (
    input logic           clk,
    input logic           reset_n,
    bus_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                    state_q, state_d;
    logic                      rr_last_q, rr_last_d;
    logic                      sel_q, sel_d;
    logic                      we_q, we_d;
    logic [ADDR_BIT_WIDTH-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_BIT_WIDTH-1:0] dbus_out_q, dbus_out_d;
    logic [WAIT_CNT_WIDTH-1:0] wcnt_q, wcnt_d;
    logic                      m0_gnt_q, m0_gnt_d, m1_gnt_q, m1_gnt_d;
    logic                      m0_ack_q, m0_ack_d, m1_ack_q, m1_ack_d;
    logic [DATA_BIT_WIDTH-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
    logic                      pick1;
    logic [ADDR_BIT_WIDTH-1:0] win_addr;
    logic                      wr_en;

`ifdef BUS_ARB_FIXED_PRIO_EN
    assign pick1 = bus.m1_req & ~bus.m0_req;
`else
    assign pick1 = bus.m1_req & (~bus.m0_req | ~rr_last_q);
`endif
    assign win_addr = pick1 ? bus.m1_addr : bus.m0_addr;
    // Write strobe only in the final ACCESS cycle so the slave sees exactly one write edge.
    assign wr_en    = (state_q == ACCESS) && (wcnt_q == '0) && we_q;

    always_comb begin
        state_d    = state_q;
        rr_last_d  = rr_last_q;
        sel_d      = sel_q;
        we_d       = we_q;
        bus_addr_d = bus_addr_q;
        dbus_out_d = dbus_out_q;
        wcnt_d     = wcnt_q;
        m0_gnt_d   = m0_gnt_q;
        m1_gnt_d   = m1_gnt_q;
        m0_ack_d   = m0_ack_q;
        m1_ack_d   = m1_ack_q;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
        case (state_q)
            IDLE: if (bus.m0_req | bus.m1_req) begin
                sel_d      = pick1;
                rr_last_d  = pick1;
                we_d       = pick1 ? bus.m1_we : bus.m0_we;
                bus_addr_d = win_addr;
                dbus_out_d = pick1 ? bus.m1_wdata : bus.m0_wdata;
                wcnt_d     = win_addr[28] ? WAIT_CNT_WIDTH'(DEV_WAIT) : '0;
                m0_gnt_d   = ~pick1;
                m1_gnt_d   = pick1;
                state_d    = ACCESS;
            end
            ACCESS: if (wcnt_q != '0) begin
                wcnt_d = wcnt_q - 1'b1;
            end else begin
                m0_rdata_d = (!we_q && !sel_q) ? bus.dbus_in : m0_rdata_q;
                m1_rdata_d = (!we_q && sel_q) ? bus.dbus_in : m1_rdata_q;
                m0_gnt_d   = 1'b0;
                m1_gnt_d   = 1'b0;
                m0_ack_d   = ~sel_q;
                m1_ack_d   = sel_q;
                state_d    = DONE;
            end
            DONE: begin
                m0_ack_d = 1'b0;
                m1_ack_d = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rr_last_q  <= 1'b1;
            sel_q      <= 1'b0;
            we_q       <= 1'b0;
            bus_addr_q <= '0;
            dbus_out_q <= '0;
            wcnt_q     <= '0;
            m0_gnt_q   <= 1'b0;
            m1_gnt_q   <= 1'b0;
            m0_ack_q   <= 1'b0;
            m1_ack_q   <= 1'b0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_last_q  <= rr_last_d;
            sel_q      <= sel_d;
            we_q       <= we_d;
            bus_addr_q <= bus_addr_d;
            dbus_out_q <= dbus_out_d;
            wcnt_q     <= wcnt_d;
            m0_gnt_q   <= m0_gnt_d;
            m1_gnt_q   <= m1_gnt_d;
            m0_ack_q   <= m0_ack_d;
            m1_ack_q   <= m1_ack_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

    assign bus.m0_gnt    = m0_gnt_q;
    assign bus.m1_gnt    = m1_gnt_q;
    assign bus.m0_ack    = m0_ack_q;
    assign bus.m1_ack    = m1_ack_q;
    assign bus.m0_rdata  = m0_rdata_q;
    assign bus.m1_rdata  = m1_rdata_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.dbus_out  = dbus_out_q;
    assign bus.bus_wrtEn = wr_en;
    assign bus.dbus_oe   = wr_en;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed checks of bus_arbiter; dut_a uses DEV_WAIT=2, dut_b uses DEV_WAIT=3.
module tb_bus_arbiter;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int n_tests = 0;
    int n_fail = 0;
    int wr_cnt_a = 0;
    int wr_cnt_b = 0;
    logic [31:0] wr_addr_a = '0;
    logic [31:0] wr_data_a = '0;

    always #5 clk = ~clk;

    bus_arbiter_if #(.ADDR_BIT_WIDTH(32), .DATA_BIT_WIDTH(32)) ifa ();
    bus_arbiter_if #(.ADDR_BIT_WIDTH(32), .DATA_BIT_WIDTH(32)) ifb ();

    bus_arbiter #(.DEV_WAIT(2)) dut_a (.clk(clk), .reset_n(reset_n), .bus(ifa));
    bus_arbiter #(.DEV_WAIT(3)) dut_b (.clk(clk), .reset_n(reset_n), .bus(ifb));

    // Slave model: a write lands on every edge where the strobe is high.
    always @(posedge clk) begin
        if (ifa.bus_wrtEn) begin
            wr_cnt_a  <= wr_cnt_a + 1;
            wr_addr_a <= ifa.bus_addr;
            wr_data_a <= ifa.dbus_out;
        end
        if (ifb.bus_wrtEn) wr_cnt_b <= wr_cnt_b + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int guard;
        logic [3:0] seq;
        logic [3:0] mask;
        {ifa.m0_req, ifa.m0_we, ifa.m0_addr, ifa.m0_wdata} = '0;
        {ifa.m1_req, ifa.m1_we, ifa.m1_addr, ifa.m1_wdata, ifa.dbus_in} = '0;
        {ifb.m0_req, ifb.m0_we, ifb.m0_addr, ifb.m0_wdata} = '0;
        {ifb.m1_req, ifb.m1_we, ifb.m1_addr, ifb.m1_wdata, ifb.dbus_in} = '0;
        tick();
        tick();
        check("rst_bus_addr", ifa.bus_addr, 32'h0);
        check("rst_wrtEn_oe", {30'd0, ifa.bus_wrtEn, ifa.dbus_oe}, 32'h0);
        check("rst_dbus_out", ifa.dbus_out, 32'h0);
        check("rst_gnt_ack", {28'd0, ifa.m0_gnt, ifa.m1_gnt, ifa.m0_ack, ifa.m1_ack}, 32'h0);
        check("rst_rdata", ifa.m0_rdata | ifa.m1_rdata, 32'h0);
        reset_n = 1'b1;
        tick();

        // M0 memory write
        ifa.m0_req = 1'b1; ifa.m0_we = 1'b1; ifa.m0_addr = 32'h10; ifa.m0_wdata = 32'hDEADBEEF;
        tick();
        ifa.m0_wdata = 32'h0;
        check("wr_gnt", {31'd0, ifa.m0_gnt}, 32'h1);
        check("wr_strobe", {30'd0, ifa.bus_wrtEn, ifa.dbus_oe}, 32'h3);
        check("wr_addr", ifa.bus_addr, 32'h10);
        check("wr_data", ifa.dbus_out, 32'hDEADBEEF);
        tick();
        check("wr_ack_at_2", {30'd0, ifa.m0_ack, ifa.m0_gnt}, 32'h2);
        check("wr_strobe_off", {31'd0, ifa.bus_wrtEn}, 32'h0);
        check("wr_count", wr_cnt_a, 32'd1);
        check("wr_slave_data", wr_data_a, 32'hDEADBEEF);
        check("wr_slave_addr", wr_addr_a, 32'h10);
        check("wr_m1_quiet", {31'd0, ifa.m1_gnt | ifa.m1_ack} | ifa.m1_rdata, 32'h0);
        ifa.m0_req = 1'b0;
        tick();
        check("wr_ack_pulse", {31'd0, ifa.m0_ack}, 32'h0);

        // M0 device read with two wait states; data valid only in the last ACCESS cycle
        ifa.m0_req = 1'b1; ifa.m0_we = 1'b0; ifa.m0_addr = 32'h1000_0004; ifa.dbus_in = 32'hFFFF_0000;
        tick();
        ifa.m0_addr = 32'h0;
        check("dev_addr_c0", ifa.bus_addr, 32'h1000_0004);
        tick();
        check("dev_addr_c1", ifa.bus_addr, 32'h1000_0004);
        check("dev_no_ack_c1", {31'd0, ifa.m0_ack}, 32'h0);
        tick();
        check("dev_addr_c2", ifa.bus_addr, 32'h1000_0004);
        check("dev_gnt_c2", {30'd0, ifa.m0_gnt, ifa.bus_wrtEn}, 32'h2);
        ifa.dbus_in = 32'h0000_00A5;
        tick();
        check("dev_ack_at_4", {31'd0, ifa.m0_ack}, 32'h1);
        check("dev_rdata", ifa.m0_rdata, 32'hA5);
        ifa.m0_req = 1'b0; ifa.dbus_in = 32'h0;
        tick();

        // M1 memory read
        base = wr_cnt_a;
        ifa.m1_req = 1'b1; ifa.m1_we = 1'b0; ifa.m1_addr = 32'h10; ifa.dbus_in = 32'hDEADBEEF;
        tick();
        check("rd_gnt", {30'd0, ifa.m1_gnt, ifa.m0_gnt}, 32'h2);
        tick();
        check("rd_ack", {31'd0, ifa.m1_ack}, 32'h1);
        check("rd_rdata", ifa.m1_rdata, 32'hDEADBEEF);
        check("rd_m0_rdata_kept", ifa.m0_rdata, 32'hA5);
        check("rd_no_write", wr_cnt_a - base, 32'd0);
        ifa.m1_req = 1'b0; ifa.dbus_in = 32'h0;
        tick();

        // Both requesting continuously for four transfers
        ifa.m0_req = 1'b1; ifa.m1_req = 1'b1; ifa.m0_we = 1'b0; ifa.m1_we = 1'b0;
        ifa.m0_addr = 32'h40; ifa.m1_addr = 32'h80;
        seq = '0;
        for (int k = 0; k < 4; k++) begin
            guard = 0;
            do begin
                tick();
                guard++;
            end while (!(ifa.m0_ack | ifa.m1_ack) && guard < 10);
            check("rr_ack_seen", {31'd0, guard < 10}, 32'h1);
            check("rr_one_ack", {31'd0, ifa.m0_ack & ifa.m1_ack}, 32'h0);
            seq[k] = ifa.m1_ack;
        end
`ifdef BUS_ARB_FIXED_PRIO_EN
        check("grant_order", {28'd0, seq}, 32'h0);
`else
        check("grant_order", {28'd0, seq}, 32'hA);
`endif
        ifa.m0_req = 1'b0; ifa.m1_req = 1'b0;
        tick();
        tick();

        // Device write with three wait states on dut_b
        base = wr_cnt_b;
        ifb.m0_req = 1'b1; ifb.m0_we = 1'b1; ifb.m0_addr = 32'h1000_0008; ifb.m0_wdata = 32'h1234_5678;
        mask = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            mask[i] = ifb.bus_wrtEn;
        end
        check("dw_strobe_mask", {28'd0, mask}, 32'h8);
        check("dw_data", ifb.dbus_out, 32'h1234_5678);
        tick();
        check("dw_ack_at_5", {31'd0, ifb.m0_ack}, 32'h1);
        check("dw_one_write", wr_cnt_b - base, 32'd1);
        ifb.m0_req = 1'b0;
        tick();

        // Reset mid-ACCESS of a device write aborts it
        base = wr_cnt_b;
        ifb.m0_req = 1'b1;
        tick();
        tick();
        check("abort_pre_gnt", {31'd0, ifb.m0_gnt}, 32'h1);
        reset_n = 1'b0;
        ifb.m0_req = 1'b0;
        #1;
        check("abort_drop", {28'd0, ifb.bus_wrtEn, ifb.dbus_oe, ifb.m0_gnt, ifb.m0_ack}, 32'h0);
        tick();
        check("abort_no_write", wr_cnt_b - base, 32'd0);
        reset_n = 1'b1;
        ifb.m1_req = 1'b1; ifb.m1_we = 1'b0; ifb.m1_addr = 32'h20; ifb.dbus_in = 32'h0BAD_F00D;
        tick();
        check("post_rst_gnt", {30'd0, ifb.m1_gnt, ifb.m0_gnt}, 32'h2);
        tick();
        check("post_rst_ack", {30'd0, ifb.m1_ack, ifb.m0_ack}, 32'h2);
        check("post_rst_rdata", ifb.m1_rdata, 32'h0BAD_F00D);
        ifb.m1_req = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
